// File: rtl/tpu_pkg.sv
// Shared constants for the TPU C-buffer drain path: widths, beat count,
// drain FSM encoding, prefetch-slot encoding and the beat slicing helper.
package tpu_pkg;

  localparam int DATA_W     = 128;
  localparam int BEAT_W     = 32;
  localparam int IDX_W      = 16;
  localparam int BEATS      = DATA_W / BEAT_W;
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  localparam logic [1:0] PF_NONE   = 2'd0;
  localparam logic [1:0] PF_ISSUED = 2'd1;
  localparam logic [1:0] PF_READY  = 2'd2;

  // Beat k is the k-th slice counted from the MSB, so column 0 leaves first.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [DATA_W-1:0] row,
                                                   input logic [BEAT_CNT_W-1:0] k);
    logic [BEAT_W-1:0] s;
    s = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (k == BEAT_CNT_W'(i)) begin
        s = row[DATA_W-1-i*BEAT_W -: BEAT_W];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/tpu_row_serializer.sv
// Holds one C row and streams it out as BEATS beats over valid/ready.
// A load presents beat 0 on the next cycle; loading is only done while idle.
module tpu_row_serializer
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last_row,
  input  logic              ready,
  output logic              valid,
  output logic [BEAT_W-1:0] data,
  output logic              last,
  output logic              row_done
);

  logic [DATA_W-1:0]     row_buf_r;
  logic [BEAT_CNT_W-1:0] beat_r;
  logic [BEAT_CNT_W-1:0] beat_nxt_s;
  logic [BEAT_W-1:0]     data_r;
  logic                  valid_r;
  logic                  last_r;
  logic                  last_row_r;
  logic                  fire_s;
  logic                  final_beat_s;

  // Handshake and beat-position decode.
  always_comb begin
    fire_s       = valid_r && ready;
    final_beat_s = (beat_r == BEAT_CNT_W'(BEATS - 1));
    beat_nxt_s   = beat_r + BEAT_CNT_W'(1);
  end

  // Row buffer, beat counter and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf_r  <= '0;
      beat_r     <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      last_row_r <= 1'b0;
    end else if (load) begin
      row_buf_r  <= load_data;
      beat_r     <= '0;
      data_r     <= beat_slice(load_data, '0);
      valid_r    <= 1'b1;
      last_row_r <= load_last_row;
      last_r     <= load_last_row && (BEATS == 1);
    end else if (fire_s) begin
      if (!final_beat_s) begin
        beat_r <= beat_nxt_s;
        data_r <= beat_slice(row_buf_r, beat_nxt_s);
        last_r <= last_row_r && (beat_nxt_s == BEAT_CNT_W'(BEATS - 1));
      end else begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

  assign valid    = valid_r;
  assign data     = data_r;
  assign last     = last_r;
  assign row_done = fire_s && final_beat_s;

endmodule

// File: rtl/tpu_c_drain.sv
// Drains the C global buffer row by row onto a 32-bit valid/ready stream.
// Define TPU_C_DRAIN_PREFETCH_EN for ping-pong row buffers with no inter-row bubble.
module tpu_c_drain
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  C_index,
  input  logic [DATA_W-1:0] C_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_last
);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [IDX_W-1:0] num_rows_r;
  logic [IDX_W-1:0] row_r;
  logic [IDX_W-1:0] c_index_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic             accept_s;
  logic             final_row_s;
  logic             row_done_s;
  logic             advance_s;

  assign final_row_s = (row_r == (num_rows_r - IDX_W'(1)));
  assign accept_s    = (state_r == ST_IDLE) && start && (num_rows != '0);
  assign advance_s   = (state_r == ST_SEND) && row_done_s && !final_row_s;

`ifdef TPU_C_DRAIN_PREFETCH_EN
  localparam logic [2:0] ST_AFTER_ROW = ST_SEND;

  logic              sel_r;
  logic [1:0]        pf_r;
  logic              pf_issue_s;
  logic              pf_last_s;
  logic              ld_first_s;
  logic              ld_pf_s;
  logic              ld_last_s;
  logic              ld0_s, ld1_s;
  logic              v0_s, v1_s, l0_s, l1_s, rd0_s, rd1_s;
  logic [BEAT_W-1:0] d0_s, d1_s;

  // The idle buffer is refilled with row+1 while the active one is still sending.
  assign ld_first_s = (state_r == ST_CAPTURE);
  assign ld_pf_s    = (pf_r == PF_ISSUED);
  assign pf_last_s  = ((row_r + IDX_W'(1)) == (num_rows_r - IDX_W'(1)));
  assign ld_last_s  = ld_first_s ? final_row_s : pf_last_s;
  assign ld0_s      = (ld_first_s && !sel_r) || (ld_pf_s && sel_r);
  assign ld1_s      = (ld_first_s && sel_r) || (ld_pf_s && !sel_r);
  assign pf_issue_s = (state_r == ST_SEND) && (pf_r == PF_NONE) && !final_row_s && !row_done_s;

  tpu_row_serializer u_ser0 (
    .clk(clk), .rst_n(rst_n), .load(ld0_s), .load_data(C_data_out),
    .load_last_row(ld_last_s), .ready(m_ready && !sel_r),
    .valid(v0_s), .data(d0_s), .last(l0_s), .row_done(rd0_s)
  );

  tpu_row_serializer u_ser1 (
    .clk(clk), .rst_n(rst_n), .load(ld1_s), .load_data(C_data_out),
    .load_last_row(ld_last_s), .ready(m_ready && sel_r),
    .valid(v1_s), .data(d1_s), .last(l1_s), .row_done(rd1_s)
  );

  assign m_valid    = sel_r ? v1_s  : v0_s;
  assign m_data     = sel_r ? d1_s  : d0_s;
  assign m_last     = sel_r ? l1_s  : l0_s;
  assign row_done_s = sel_r ? rd1_s : rd0_s;
`else
  localparam logic [2:0] ST_AFTER_ROW = ST_ISSUE;

  tpu_row_serializer u_ser0 (
    .clk(clk), .rst_n(rst_n), .load(state_r == ST_CAPTURE), .load_data(C_data_out),
    .load_last_row(final_row_s), .ready(m_ready),
    .valid(m_valid), .data(m_data), .last(m_last), .row_done(row_done_s)
  );
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (num_rows != '0) ? ST_ISSUE : ST_FINISH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE:   state_nxt_s = ST_CAPTURE;
      ST_CAPTURE: state_nxt_s = ST_SEND;
      ST_SEND: begin
        if (row_done_s) begin
          state_nxt_s = final_row_s ? ST_FINISH : ST_AFTER_ROW;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_FINISH:  state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_nxt_s)
      ST_ISSUE, ST_CAPTURE, ST_SEND: busy_s = 1'b1;
      ST_FINISH:                     done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Row bookkeeping and read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_rows_r <= '0;
      row_r      <= '0;
      c_index_r  <= '0;
`ifdef TPU_C_DRAIN_PREFETCH_EN
      sel_r      <= 1'b0;
      pf_r       <= PF_NONE;
`endif
    end else if (accept_s) begin
      num_rows_r <= num_rows;
      row_r      <= '0;
      c_index_r  <= '0;
`ifdef TPU_C_DRAIN_PREFETCH_EN
      sel_r      <= 1'b0;
      pf_r       <= PF_NONE;
`endif
    end else if (advance_s) begin
      row_r      <= row_r + IDX_W'(1);
`ifdef TPU_C_DRAIN_PREFETCH_EN
      sel_r      <= ~sel_r;
      pf_r       <= PF_NONE;
    end else if (pf_issue_s) begin
      c_index_r  <= row_r + IDX_W'(1);
      pf_r       <= PF_ISSUED;
    end else if (pf_r == PF_ISSUED) begin
      pf_r       <= PF_READY;
`else
      c_index_r  <= row_r + IDX_W'(1);
`endif
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign C_index = c_index_r;

endmodule
